mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier with a fixed WIDTH-cycle latency.
// Returns the low WIDTH product bits plus an exact overflow flag for the full-width product.
module mult_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             lost_q, lost_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             overflow_q, overflow_d;

   // Single ripple-carry adder shared by every RUN cycle: acc + mcand, carry-in 0.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
         assign sum[gi]      = acc_q[gi] ^ mcand_q[gi] ^ carry[gi];
         assign carry[gi+1]  = (acc_q[gi] & mcand_q[gi]) |
                               (carry[gi] & (acc_q[gi] ^ mcand_q[gi]));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         lost_q     <= 1'b0;
         ovf_acc_q  <= 1'b0;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         lost_q     <= lost_d;
         ovf_acc_q  <= ovf_acc_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      count_d    = count_q;
      lost_d     = lost_q;
      ovf_acc_d  = ovf_acc_q;
      product_d  = product_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d   = X;
               mplier_d  = Y;
               acc_d     = '0;
               count_d   = '0;
               lost_d    = 1'b0;
               ovf_acc_d = 1'b0;
               state_d   = RUN;
            end else begin
               state_d   = IDLE;
            end
         end
         RUN: begin
            // A set multiplier bit overflows if the add carries out or the
            // shifted multiplicand already lost a high bit.
            if (mplier_q[0]) begin
               acc_d = sum;
               if (carry[WIDTH] || lost_q)
                  ovf_acc_d = 1'b1;
            end
            if (mcand_q[WIDTH-1])
               lost_d = 1'b1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               product_d  = acc_d;
               overflow_d = ovf_acc_d;
               state_d    = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign product  = product_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: stimulus queues expected results and completion
// cycles, a negedge monitor checks every done pulse and that outputs hold between completions.
module tb_mult_seq_ctrl;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         busy;
   logic         done;
   logic [W-1:0] product;
   logic         overflow;

   typedef struct {
      logic [W-1:0] p;
      logic         o;
      int           c;
   } exp_t;

   exp_t         sb[$];
   int           cyc;
   int           checks;
   int           errors;
   logic [W-1:0] hold_p;
   logic         hold_o;

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .X        (X),
      .Y        (Y),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      hold_p = '0;
      hold_o = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_p = '0;
            hold_o = 1'b0;
         end else begin
            if (done) begin
               checks++;
               if (busy) begin
                  errors++;
                  $display("FAIL busy_during_done: busy=%0b required 0", busy);
               end
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: done pulse at cycle %0d with nothing outstanding", cyc);
               end else begin
                  e = sb.pop_front();
                  checks++;
                  if (cyc != e.c) begin
                     errors++;
                     $display("FAIL done_cycle: got cycle %0d required %0d", cyc, e.c);
                  end
                  hold_p = e.p;
                  hold_o = e.o;
                  $display("txn done cycle=%0d product=%h overflow=%0b expected %h/%0b",
                           cyc, product, overflow, e.p, e.o);
               end
            end
            checks++;
            if (product !== hold_p || overflow !== hold_o) begin
               errors++;
               $display("FAIL result_hold: got product=%h overflow=%0b required %h/%0b",
                        product, overflow, hold_p, hold_o);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ep, input logic eo);
      exp_t e;
      start = 1'b1;
      X     = x;
      Y     = y;
      @(posedge clk);
      #1;
      e.p = ep;
      e.o = eo;
      e.c = cyc + W;
      sb.push_back(e);
      $display("txn start cycle=%0d X=%h Y=%h", cyc, x, y);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL completion_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ep, input logic eo);
      issue(x, y, ep, eo);
      wait_idle();
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL %s: busy=%0b done=%0b product=%h overflow=%0b required all 0",
                  name, busy, done, product, overflow);
      end
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b1;
      X      = 32'd5;
      Y      = 32'd5;
      repeat (2) @(negedge clk);
      check_idle("reset_state");
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      run_op(32'd6,        32'd7,        32'd42,        1'b0);
      run_op(32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  1'b0);
      run_op(32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  1'b1);
      run_op(32'h00010000, 32'h00010000, 32'h00000000,  1'b1);
      run_op(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF,  1'b0);
      run_op(32'h80000000, 32'd3,        32'h80000000,  1'b1);
      run_op(32'd0,        32'hFFFFFFFF, 32'd0,         1'b0);
      run_op(32'h12345678, 32'd0,        32'd0,         1'b0);

      // Start pulse while running must be ignored.
      issue(32'd3, 32'd5, 32'd15, 1'b0);
      repeat (8) @(negedge clk);
      start = 1'b1;
      X     = 32'd9;
      Y     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Back-to-back: start held during the DONE cycle.
      issue(32'h100, 32'h100, 32'h10000, 1'b0);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_done_wait: done=%0b required 1", done);
      end
      issue(32'd2, 32'd3, 32'd6, 1'b0);
      wait_idle();

      // Reset in the middle of a run: outputs clear at once, no done follows.
      issue(32'hDEAD, 32'h10, 32'hDEAD0, 1'b0);
      repeat (11) @(posedge clk);
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      check_idle("async_reset_midrun");
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_idle("no_done_after_reset");
      run_op(32'd11, 32'd13, 32'd143, 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
